// File: rtl/sw_s_stream_responder_pkg.sv
// Shared types and sizing for the S-sequence responder: base encodings, chunk layout
// and the default PE array width.
`ifndef SW_PE_ARRAY_SIZE
`define SW_PE_ARRAY_SIZE 8
`endif

package sw_s_stream_responder_pkg;

   typedef enum logic [1:0] {
      BASE_A = 2'd0,
      BASE_C = 2'd1,
      BASE_G = 2'd2,
      BASE_T = 2'd3
   } base_e;

   localparam int PE_SIZE_DEFAULT = `SW_PE_ARRAY_SIZE;

   function automatic int cnt_width(input int pe_size);
      return $clog2(pe_size) + 1;
   endfunction

   localparam int CNT_W_DEFAULT = cnt_width(PE_SIZE_DEFAULT);

   typedef struct packed {
      logic [2*PE_SIZE_DEFAULT-1:0] data;
      logic [CNT_W_DEFAULT-1:0]     cnt;
   } chunk_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_PEND = 1'b1
   } resp_state_e;

endpackage

// File: rtl/sw_chunk_fifo2.sv
// Two-entry chunk FIFO; a pop and a push may share a cycle even when full.
module sw_chunk_fifo2 #(
   parameter int WIDTH = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic             do_pop;
   logic             do_push;

   assign empty    = (count == 2'd0);
   assign full     = (count == 2'd2);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: payload storage carries no reset; count/empty gate every read of it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_pop)  rd_ptr <= ~rd_ptr;
         if (do_push) wr_ptr <= ~wr_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/sw_s_stream_responder.sv
// Packs the host base stream into PE_SIZE-base chunks and answers each chunk request
// from the data processor out of a 2-entry queue.
module sw_s_stream_responder
   import sw_s_stream_responder_pkg::*;
#(
   parameter int PE_SIZE = PE_SIZE_DEFAULT,
   parameter int CNT_W   = cnt_width(PE_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           i_base,
   input  logic                 i_base_valid,
   input  logic                 i_base_last,
   output logic                 o_base_ready,
   input  logic                 i_request_s,
   output logic [2*PE_SIZE-1:0] o_s,
   output logic [CNT_W-1:0]     o_s_valid,
   output logic                 o_s_strobe,
   output logic                 o_seq_done,
   output logic                 o_underrun
);

   localparam int FILL_W  = $clog2(PE_SIZE);
   localparam int CHUNK_W = 2*PE_SIZE + CNT_W;

   typedef struct packed {
      logic [2*PE_SIZE-1:0] data;
      logic [CNT_W-1:0]     cnt;
   } pe_chunk_t;

   logic [FILL_W-1:0]    fill;
   logic [2*PE_SIZE-1:0] pack_data;
   logic [2*PE_SIZE-1:0] chunk_data;
   logic                 pend_marker;
   logic                 accept;
   logic                 slot_last;
   logic                 chunk_push;
   logic                 marker_push;
   logic                 q_push;
   logic                 q_pop;
   logic                 q_full;
   logic                 q_empty;
   logic                 underrun_set;
   pe_chunk_t            push_chunk;
   pe_chunk_t            head_chunk;
   resp_state_e          state;
   resp_state_e          state_nxt;

   assign o_base_ready = !rst && !q_full && !pend_marker;
   assign accept       = i_base_valid && o_base_ready;
   assign slot_last    = (fill == FILL_W'(PE_SIZE-1));
   assign chunk_push   = accept && (slot_last || i_base_last);
   // The zero-count end marker may take the slot a same-cycle pop frees.
   assign marker_push  = pend_marker && (!q_full || q_pop);
   assign q_push       = chunk_push || marker_push;

   always_comb begin
      chunk_data = pack_data;
      for (int k = 0; k < PE_SIZE; k++) begin
         if (fill == FILL_W'(k)) chunk_data[2*k +: 2] = i_base;
      end
   end

   always_comb begin
      push_chunk = '0;
      if (!marker_push) begin
         push_chunk.data = chunk_data;
         push_chunk.cnt  = CNT_W'(fill) + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill        <= '0;
         pack_data   <= '0;
         pend_marker <= 1'b0;
      end else begin
         if (chunk_push) begin
            fill      <= '0;
            pack_data <= '0;
         end else if (accept) begin
            fill      <= fill + FILL_W'(1);
            pack_data <= chunk_data;
         end
         if (chunk_push && i_base_last && slot_last) pend_marker <= 1'b1;
         else if (marker_push)                       pend_marker <= 1'b0;
      end
   end

   sw_chunk_fifo2 #(.WIDTH(CHUNK_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (push_chunk),
      .pop       (q_pop),
      .pop_data  (head_chunk),
      .full      (q_full),
      .empty     (q_empty)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt    = state;
      q_pop        = 1'b0;
      underrun_set = 1'b0;
      case (state)
         R_IDLE: begin
            if (i_request_s) begin
               if (q_empty) begin
                  underrun_set = 1'b1;
                  state_nxt    = R_PEND;
               end else begin
                  q_pop = 1'b1;
               end
            end
         end
         R_PEND: begin
            underrun_set = i_request_s;
            if (!q_empty) begin
               q_pop     = 1'b1;
               state_nxt = R_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= R_IDLE;
         o_s        <= '0;
         o_s_valid  <= '0;
         o_s_strobe <= 1'b0;
         o_seq_done <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_s_strobe <= q_pop;
         if (q_pop) begin
            o_s       <= head_chunk.data;
            o_s_valid <= head_chunk.cnt;
         end
         if (underrun_set) o_underrun <= 1'b1;
         if (q_pop && (head_chunk.cnt < CNT_W'(PE_SIZE))) o_seq_done <= 1'b1;
         else if (accept)                                 o_seq_done <= 1'b0;
      end
   end

endmodule

// File: doc/sw_s_stream_responder.md
Name: sw_s_stream_responder

Overview:
- Responder end of the accelerator's S-sequence request channel. It answers each request pulse from the data processor with one packed chunk of up to PE_SIZE bases and a valid-base count.
- Upstream it accepts a host base stream (2-bit bases, valid/ready, last flag) and packs it into chunks.
- A 2-entry chunk queue lets a request normally be answered one cycle later without stalling the PE array.

Parameters:
- PE_SIZE, 8, bases per chunk; must match the PE array size.
- CNT_W, $clog2(PE_SIZE)+1, width of the base count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_base  in  2  host base; encoding A=0, C=1, G=2, T=3
- i_base_valid  in  1  host base valid
- i_base_last  in  1  marks the final base of the sequence; qualified by i_base_valid
- o_base_ready  out  1  responder can accept a base this cycle
- i_request_s  in  1  single-cycle chunk request from the data processor
- o_s  out  2*PE_SIZE  chunk data; base k sits at bits [2k+1:2k]
- o_s_valid  out  CNT_W  number of valid bases in o_s (0..PE_SIZE)
- o_s_strobe  out  1  one-cycle pulse: o_s/o_s_valid were updated this cycle
- o_seq_done  out  1  high from the end-of-sequence chunk delivery until the next first base is accepted
- o_underrun  out  1  sticky; a request found the queue empty; cleared by reset only

Behaviour:
- Reset: o_s=0, o_s_valid=0, o_s_strobe=0, o_base_ready=0 during reset (1 in the first cycle after), o_seq_done=0, o_underrun=0. Packer and queue are emptied. Reset mid-sequence discards all partial and queued data.
- Packer:
  - Holds a fill counter (0..PE_SIZE-1).
  - On i_base_valid && o_base_ready, writes the base at slot fill and increments fill.
  - When the slot filled is PE_SIZE-1, or i_base_last is set, the packer pushes {data, count=fill+1} to the queue and clears fill. Unused slots are zero.
  - o_base_ready = queue not full && !pend_marker.
- End marker:
  - If the last base completes a full chunk (count==PE_SIZE), the packer sets pend_marker.
  - pend_marker pushes a zero-count chunk as soon as a queue slot is free, then clears.
  - Rule: a chunk with count < PE_SIZE terminates the sequence.
- Queue:
  - 2 entries, FIFO.
  - A push and a pop in the same cycle are both allowed, including when full (pop happens first).
- Response FSM:
  - R_IDLE: on i_request_s, if the queue is non-empty, pop the head. o_s/o_s_valid register it and o_s_strobe pulses in the next cycle (latency 1). If the queue is empty, set o_underrun and go to R_PEND.
  - R_PEND: on the first cycle the queue is non-empty, pop and deliver as above (strobe the following cycle), then return to R_IDLE.
  - A request arriving in R_PEND is a protocol error: ignore it and set o_underrun.
  - A request in the same cycle as a push into an empty queue counts as empty. Go to R_PEND; delivery follows one cycle later.
- o_s and o_s_valid hold their last delivered values between strobes.
- o_seq_done is set in the cycle o_s_strobe delivers a chunk with count < PE_SIZE. It clears when the next sequence's first base is accepted.
- A new sequence may start packing as soon as the previous last base is accepted; there is no gap requirement.

Decomposition:
- Shared package/header: base encodings, PE_SIZE default tied to the global PE array size macro, the CNT_W formula, and a chunk struct {data[2*PE_SIZE], cnt[CNT_W]}.
- One natural sub-module: sw_chunk_fifo2, a 2-entry chunk FIFO with full/empty flags and same-cycle push/pop.
- The packer and the response FSM stay in the top of the block.

Test Plan (PE_SIZE=4):
- Stream of 6 bases A,C,G,T,T,G (last on the 6th), requests after both chunks are queued: first strobe gives o_s=0xE4, cnt=4; second gives o_s=0x0B, cnt=2; o_seq_done=1 after the second.
- 4 bases G,G,G,G with last, then two requests: chunk o_s=0xAA, cnt=4, then o_s=0, cnt=0; o_seq_done rises on the zero-count chunk.
- Request with an empty queue, then 4 bases fed: o_underrun=1, and o_s_strobe occurs one cycle after the 4th base is accepted, cnt=4.
- Feed 12 bases with no requests: o_base_ready drops after the 8th base (queue full); issue a request: the ready pulse resumes and exactly 12 bases are delivered across 3 requests.
- Assert rst mid-sequence after 5 bases: all outputs return to reset values; a new 3-base sequence yields one chunk with cnt=3 and no stale data.
- Back-to-back requests every cycle with a full queue: strobes on consecutive cycles, FIFO order preserved, no underrun.
